// File: rtl/mmu.sv
// mmu: 3x3 weight-stationary systolic matrix-multiply unit.
// Weights are shifted in top-down while control=1 and then stay in the PEs.
// Data enters from the left and moves one column per compute edge.
// Partial sums move one row down per compute edge.
// Each bottom-row PE drives its column slice of acc_out directly, with no output register.
// Optional build macro: SIGNED_EN. When it is defined, operands are two's-complement
// and each product is sign-extended into the 24-bit sum. When it is undefined,
// operands are unsigned and each product is zero-extended.
module mmu (
    input  logic        clk,
    input  logic        reset,
    input  logic        control,
    input  logic [23:0] wt_arr,
    input  logic [23:0] data_arr,
    output logic [71:0] acc_out
);

    logic [7:0]  w_q  [3][3];
    logic [7:0]  d_q  [3][3];
    logic [23:0] p_q  [3][3];

    logic [7:0]  win  [3][3];
    logic [7:0]  din  [3][3];
    logic [23:0] pin  [3][3];
    logic [23:0] prod [3][3];

    // 8x8 multiply, widened to the 24-bit column-sum width.
    function automatic logic [23:0] mac_prod(input logic [7:0] a, input logic [7:0] b);
`ifdef SIGNED_EN
        logic signed [15:0] pr;
        pr = $signed(a) * $signed(b);
        return {{8{pr[15]}}, pr};
`else
        logic [15:0] pr;
        pr = a * b;
        return {8'd0, pr};
`endif
    endfunction

    // Neighbour wiring: weights from above, data from the left, psums from above.
    for (genvar i = 0; i < 3; i++) begin : g_row
        for (genvar j = 0; j < 3; j++) begin : g_col
            if (i == 0) begin : g_top
                assign win[i][j] = wt_arr[8*j +: 8];
                assign pin[i][j] = '0;
            end else begin : g_inner_r
                assign win[i][j] = w_q[i-1][j];
                assign pin[i][j] = p_q[i-1][j];
            end
            if (j == 0) begin : g_left
                assign din[i][j] = data_arr[8*i +: 8];
            end else begin : g_inner_c
                assign din[i][j] = d_q[i][j-1];
            end
            assign prod[i][j] = mac_prod(din[i][j], w_q[i][j]);
        end
    end

    // PE registers. In load mode only the weights shift; data and psums hold.
    // In compute mode the weights hold while data and psums advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    w_q[i][j] <= '0;
                    d_q[i][j] <= '0;
                    p_q[i][j] <= '0;
                end
            end
        end else if (control) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    w_q[i][j] <= win[i][j];
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    d_q[i][j] <= din[i][j];
                    p_q[i][j] <= pin[i][j] + prod[i][j];
                end
            end
        end
    end

    // The bottom-row psums are the column outputs.
    for (genvar j = 0; j < 3; j++) begin : g_out
        assign acc_out[24*j +: 24] = p_q[2][j];
    end

endmodule

// File: tb/tb_mmu.sv
// tb_mmu: scoreboard bench for the 3x3 systolic MMU.
// Each vector is scheduled with row skew. When a vector is scheduled, the bench
// computes its expected column sums from its own copy of the weights and queues
// them with the compute edge at which each sum becomes valid.
module tb_mmu;

    logic        clk = 1'b0;
    logic        reset;
    logic        control;
    logic [23:0] wt_arr;
    logic [23:0] data_arr;
    logic [71:0] acc_out;

    mmu dut (
        .clk      (clk),
        .reset    (reset),
        .control  (control),
        .wt_arr   (wt_arr),
        .data_arr (data_arr),
        .acc_out  (acc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_n;
        int          col;
        logic [23:0] val;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  wm    [3][3];
    logic [7:0]  sched [32][3];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int sx(input logic [7:0] b);
`ifdef SIGNED_EN
        return int'($signed(b));
`else
        return int'(b);
`endif
    endfunction

    task automatic clear_sched();
        for (int e = 0; e < 32; e++)
            for (int i = 0; i < 3; i++)
                sched[e][i] = 8'd0;
    endtask

    // Schedule vector x starting at compute edge s, then queue its expected column sums.
    task automatic add_vec(input int s, input logic [7:0] x0, input logic [7:0] x1,
                           input logic [7:0] x2, input string tag);
        logic [7:0] x [3];
        int sum;
        x[0] = x0; x[1] = x1; x[2] = x2;
        for (int i = 0; i < 3; i++) sched[s+i][i] = x[i];
        for (int j = 0; j < 3; j++) begin
            sum = 0;
            for (int i = 0; i < 3; i++) sum += sx(x[i]) * sx(wm[i][j]);
            sb.push_back('{s + 2 + j, j, 24'(sum), $sformatf("%s_c%0d", tag, j)});
        end
    endtask

    task automatic edge_step(input int e);
        control  = 1'b0;
        data_arr = {sched[e][2], sched[e][1], sched[e][0]};
        @(posedge clk);
        #1;
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].edge_n == e) begin
                check(sb[k].tag, 72'(acc_out[24*sb[k].col +: 24]), 72'(sb[k].val));
                sb.delete(k);
            end
        end
    endtask

    task automatic run_burst(input int first, input int n);
        for (int e = first; e < n; e++) edge_step(e);
        sb.delete();
        clear_sched();
        data_arr = 24'd0;
    endtask

    // Rows are given top-down, and byte j of each row is column j. The bottom row is presented first.
    task automatic load_weights(input logic [23:0] r0, input logic [23:0] r1, input logic [23:0] r2);
        logic [23:0] rows [3];
        rows[0] = r0; rows[1] = r1; rows[2] = r2;
        control = 1'b1;
        for (int k = 2; k >= 0; k--) begin
            wt_arr   = rows[k];
            data_arr = 24'($urandom);
            @(posedge clk);
            #1;
        end
        control  = 1'b0;
        data_arr = 24'd0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                wm[i][j] = rows[i][8*j +: 8];
    endtask

    initial begin
        reset    = 1'b0;
        control  = 1'b0;
        wt_arr   = 24'd0;
        data_arr = 24'd0;
        clear_sched();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                wm[i][j] = 8'd0;

        // Reset held with random inputs.
        for (int k = 0; k < 5; k++) begin
            control  = 1'($urandom);
            wt_arr   = 24'($urandom);
            data_arr = 24'($urandom);
            @(posedge clk);
            #1;
            check("rst_hold", acc_out, 72'd0);
        end
        control  = 1'b0;
        wt_arr   = 24'd0;
        data_arr = 24'd0;
        reset    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("rst_zero_data", acc_out, 72'd0);
        end

        // Identity weights with x=(1,2,3).
        load_weights(24'h000001, 24'h000100, 24'h010000);
        add_vec(0, 8'd1, 8'd2, 8'd3, "ident");
        run_burst(0, 6);

        // General weights: col0=16, col1=10, col2=16.
        load_weights(24'h040302, 24'h030201, 24'h020104);
        add_vec(0, 8'd1, 8'd2, 8'd3, "general");
        run_burst(0, 6);

        // Maximum operands.
        load_weights(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
        add_vec(0, 8'hFF, 8'hFF, 8'hFF, "maxval");
        run_burst(0, 6);

        // Weights of 0xFF with x=0x80 (the signed case gives 384 per column).
        add_vec(0, 8'h80, 8'h80, 8'h80, "neg");
        run_burst(0, 6);

        // Streaming back-to-back vectors through the identity weights.
        load_weights(24'h000001, 24'h000100, 24'h010000);
        add_vec(0, 8'd1, 8'd2, 8'd3, "strm_a");
        add_vec(1, 8'd4, 8'd5, 8'd6, "strm_b");
        run_burst(0, 8);

        // Vector in flight across a reload of the same weights.
        load_weights(24'h040302, 24'h030201, 24'h020104);
        add_vec(0, 8'd7, 8'd9, 8'd11, "hold");
        edge_step(0);
        edge_step(1);
        load_weights(24'h040302, 24'h030201, 24'h020104);
        run_burst(2, 6);

        // Random weights and four streamed random vectors.
        load_weights(24'($urandom), 24'($urandom), 24'($urandom));
        for (int v = 0; v < 4; v++)
            add_vec(v, 8'($urandom), 8'($urandom), 8'($urandom), $sformatf("rnd%0d", v));
        run_burst(0, 9);

        // Reset asserted mid-computation.
        load_weights(24'h000001, 24'h000100, 24'h010000);
        add_vec(0, 8'd1, 8'd2, 8'd3, "midop_pre");
        edge_step(0);
        edge_step(1);
        edge_step(2);
        reset = 1'b0;
        #1;
        check("midop_async_clr", acc_out, 72'd0);
        sb.delete();
        clear_sched();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                wm[i][j] = 8'd0;
        @(posedge clk);
        #1;
        check("midop_rst_hold", acc_out, 72'd0);
        reset = 1'b1;
        add_vec(0, 8'd5, 8'd6, 8'd7, "noreload");
        run_burst(0, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
